gpr_operand_fetch: RTL and testbench
====================================

GPR_OPERAND_FETCH -- requirements
Module: gpr_operand_fetch

Interface
REQ-001 Parameters: none local; NTHREADS, NREGS, TidMSB and Value come from rfPhoenixPkg.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req_v / req_rdy  in / out  1 / 1  request handshake; transfer on req_v & req_rdy at a rising edge.
REQ-005 req_tid  in  TidMSB+1  thread id.
REQ-006 req_ra, req_rb, req_rc  in  6 each  register numbers.
REQ-007 req_mask  in  3  operand enables, bit0=a, bit1=b, bit2=c.
REQ-008 rf_ra  out  5+TidMSB+2  regfile read address, {tid,reg}; read data returns on rf_o two cycles after the cycle in which rf_ra is presented.
REQ-009 rf_o  in  Value  regfile read data.
REQ-010 wb_wr, wb_wa, wb_i  in  1 / 5+TidMSB+2 / Value  snoop of the regfile write port.
REQ-011 out_v / out_rdy  out / in  1 / 1  result handshake.
REQ-012 out_tid, out_a, out_b, out_c  out  TidMSB+1 / Value x3  fetched operands.

Function
REQ-013 States: IDLE, ISSUE, DRAIN, OUT; req_rdy=1 only in IDLE.
REQ-014 Accept in IDLE: latch tid, the three registers and the mask; clear all operand registers and bypass flags.
- Nonzero mask -> ISSUE.
- Zero mask -> OUT.
REQ-015 ISSUE presents one enabled operand per cycle on rf_ra, in order a, b, c, skipping disabled operands.
- After the last enabled operand, go to DRAIN.
REQ-016 rf_ra SHALL be 0 in every cycle that is not an ISSUE cycle.
REQ-017 An operand issued in cycle t is captured from rf_o at the end of cycle t+2.
- DRAIN -> OUT once the last capture is complete.
- Full mask: accept at edge E0, issues in cycles 1-3, out_v first high in cycle 6.
REQ-018 Disabled operands SHALL read as 0 on their out_* port.
REQ-019 Bypass before capture: a wb_wr in cycle t+1 or t+2 with wb_wa equal to the operand address sets that operand's bypass flag and stores wb_i.
- At capture the bypass value wins over rf_o.
- The latest matching write wins.
REQ-020 Bypass after capture: a matching wb_wr after capture, including while in OUT, overwrites the captured operand at that edge.
REQ-021 A wb_wr in cycle t or earlier is not bypassed; the RAM supplies the value.
REQ-022 One write matching several operand addresses updates all of them.
REQ-023 OUT holds out_v=1 and stable outputs, subject only to REQ-020, until out_rdy=1; then return to IDLE.
- The next request is accepted no earlier than the following edge.
REQ-024 out_rdy is ignored when out_v=0; req_v is ignored outside IDLE.

Reset
REQ-025 rst forces IDLE at any state, mid-operation included, and discards in-flight reads.
- Reset values: req_rdy=1, out_v=0, rf_ra=0, out_tid=0, out_a/b/c=0, all bypass flags cleared.
REQ-026 The first accept is possible at the first edge after rst deasserts.

Structure
REQ-027 The fetch-state enum and the operand-address type, 5+TidMSB+2 bits wide, SHALL live in rfPhoenixPkg.
REQ-028 One sub-module, gpr_opnd_slot, SHALL implement a single operand's capture register, bypass flag and address compare, instantiated three times.

Verification
REQ-029 Bench models the regfile with the stated two-cycle read latency.
- mem[{tid1,r5}]=0x11.
- Request tid1, mask=001, ra=5.
- Expected: out_a=0x11, out_b=out_c=0, out_v first high in cycle 4.
REQ-030 Full mask, tid0, ra=1/rb=2/rc=3 holding 0xA/0xB/0xC.
- Expected: rf_ra sequence 1,2,3 in cycles 1-3; out_v in cycle 6; operands 0xA/0xB/0xC.
REQ-031 Write {0,2}=0x55 in the cycle after rb issues -> out_b=0x55.
- Write the same address in the issue cycle of rb -> out_b=0x55, read through the RAM.
REQ-032 Hold out_rdy=0 for 5 cycles in OUT and write {0,3}=0x77 during the hold.
- Expected: out_c changes to 0x77, out_v stays 1, then IDLE after out_rdy=1.
REQ-033 mask=000 -> out_v in cycle 1 with all operands 0.
- ra=rb=rc=4 and one write 0x99 to {0,4} after capture -> all three operands read 0x99.
REQ-034 Assert rst in cycle 2 of a full-mask fetch.
- Expected: next cycle IDLE, all outputs at reset values, no stale capture.
- A following request returns correct data.

Source files
------------

// File: rtl/gpr_operand_fetch_pkg.sv
// Shared parameters and types for the GPR operand fetch unit.
// Operand addresses are {thread id, register number}.
package rfPhoenixPkg;
    localparam int NTHREADS = 4;
    localparam int NREGS    = 64;
    localparam int TidMSB   = $clog2(NTHREADS) - 1;
    localparam int VALUE_W  = 32;

    typedef logic [VALUE_W-1:0] Value;
    typedef logic [5+TidMSB+1:0] gpr_addr_t;
    typedef logic [1:0] opnd_idx_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_ISSUE,
        FETCH_DRAIN,
        FETCH_OUT
    } fetch_state_t;

    // Lowest-numbered operand still waiting to be issued (a before b before c).
    function automatic opnd_idx_t first_opnd(input logic [2:0] pend);
        if (pend[0]) return 2'd0;
        if (pend[1]) return 2'd1;
        return 2'd2;
    endfunction
endpackage

// File: rtl/gpr_operand_fetch_opnd_slot.sv
// One operand slot: latched address, captured value and bypass flag.
// Before capture the value register doubles as bypass storage.
module gpr_opnd_slot
    import rfPhoenixPkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  gpr_addr_t load_addr,
    input  logic      inflight,
    input  logic      capture,
    input  Value      rf_o,
    input  logic      wb_wr,
    input  gpr_addr_t wb_wa,
    input  Value      wb_i,
    output gpr_addr_t addr,
    output Value      val
);
    gpr_addr_t addr_q, addr_d;
    Value      val_q, val_d;
    logic      byp_q, byp_d;
    logic      done_q, done_d;
    logic      hit;

    always_comb begin
        hit    = wb_wr && (wb_wa == addr_q);
        addr_d = addr_q;
        val_d  = val_q;
        byp_d  = byp_q;
        done_d = done_q;
        if (load) begin
            addr_d = load_addr;
            val_d  = '0;
            byp_d  = 1'b0;
            done_d = 1'b0;
        end else if (capture) begin
            // a write landing in the capture cycle is newer than anything stored
            val_d  = hit ? wb_i : (byp_q ? val_q : rf_o);
            byp_d  = 1'b0;
            done_d = 1'b1;
        end else if (hit && (inflight || done_q)) begin
            val_d  = wb_i;
            byp_d  = byp_q || inflight;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            val_q  <= '0;
            byp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            val_q  <= val_d;
            byp_q  <= byp_d;
            done_q <= done_d;
        end
    end

    assign addr = addr_q;
    assign val  = val_q;
endmodule

// File: rtl/gpr_operand_fetch.sv
// Fetches up to three operands for one thread from a two-cycle-latency
// register file, forwarding snooped write-backs into in-flight and held operands.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | one enabled operand address per cycle on rf_ra
// DRAIN | waiting for outstanding reads to return
// OUT   | operands valid, waiting for out_rdy
module gpr_operand_fetch
    import rfPhoenixPkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_v,
    output logic              req_rdy,
    input  logic [TidMSB:0]   req_tid,
    input  logic [5:0]        req_ra,
    input  logic [5:0]        req_rb,
    input  logic [5:0]        req_rc,
    input  logic [2:0]        req_mask,
    output gpr_addr_t         rf_ra,
    input  Value              rf_o,
    input  logic              wb_wr,
    input  gpr_addr_t         wb_wa,
    input  Value              wb_i,
    output logic              out_v,
    input  logic              out_rdy,
    output logic [TidMSB:0]   out_tid,
    output Value              out_a,
    output Value              out_b,
    output Value              out_c
);
    fetch_state_t    state_q, state_d;
    logic [TidMSB:0] tid_q, tid_d;
    logic [2:0]      pend_q, pend_d;
    logic            p1_v_q, p1_v_d, p2_v_q, p2_v_d;
    opnd_idx_t       p1_idx_q, p1_idx_d, p2_idx_q, p2_idx_d;
    opnd_idx_t       sel;
    logic            load;
    logic [2:0]      inflight, capture;
    gpr_addr_t       load_addr [3];
    gpr_addr_t       slot_addr [3];
    Value            slot_val  [3];

    assign load_addr[0] = {req_tid, req_ra};
    assign load_addr[1] = {req_tid, req_rb};
    assign load_addr[2] = {req_tid, req_rc};

    for (genvar i = 0; i < 3; i++) begin : g_slot
        // p1 marks a read issued last cycle, p2 one whose data is on rf_o now
        assign inflight[i] = p1_v_q && (p1_idx_q == opnd_idx_t'(i));
        assign capture[i]  = p2_v_q && (p2_idx_q == opnd_idx_t'(i));

        gpr_opnd_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load),
            .load_addr (load_addr[i]),
            .inflight  (inflight[i]),
            .capture   (capture[i]),
            .rf_o      (rf_o),
            .wb_wr     (wb_wr),
            .wb_wa     (wb_wa),
            .wb_i      (wb_i),
            .addr      (slot_addr[i]),
            .val       (slot_val[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        tid_d    = tid_q;
        pend_d   = pend_q;
        sel      = first_opnd(pend_q);
        p1_v_d   = 1'b0;
        p1_idx_d = sel;
        p2_v_d   = p1_v_q;
        p2_idx_d = p1_idx_q;
        load     = 1'b0;
        req_rdy  = 1'b0;
        out_v    = 1'b0;
        rf_ra    = '0;
        case (state_q)
            FETCH_IDLE: begin
                req_rdy = 1'b1;
                if (req_v) begin
                    load    = 1'b1;
                    tid_d   = req_tid;
                    pend_d  = req_mask;
                    state_d = (req_mask != 3'b000) ? FETCH_ISSUE : FETCH_OUT;
                end
            end
            FETCH_ISSUE: begin
                case (sel)
                    2'd0:    rf_ra = slot_addr[0];
                    2'd1:    rf_ra = slot_addr[1];
                    default: rf_ra = slot_addr[2];
                endcase
                p1_v_d = 1'b1;
                pend_d = pend_q & ~(3'b001 << sel);
                if (pend_d == 3'b000) state_d = FETCH_DRAIN;
            end
            FETCH_DRAIN: begin
                if (p2_v_q && !p1_v_q) state_d = FETCH_OUT;
            end
            FETCH_OUT: begin
                out_v = 1'b1;
                if (out_rdy) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH_IDLE;
            tid_q    <= '0;
            pend_q   <= '0;
            p1_v_q   <= 1'b0;
            p1_idx_q <= '0;
            p2_v_q   <= 1'b0;
            p2_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            tid_q    <= tid_d;
            pend_q   <= pend_d;
            p1_v_q   <= p1_v_d;
            p1_idx_q <= p1_idx_d;
            p2_v_q   <= p2_v_d;
            p2_idx_q <= p2_idx_d;
        end
    end

    assign out_tid = tid_q;
    assign out_a   = slot_val[0];
    assign out_b   = slot_val[1];
    assign out_c   = slot_val[2];
endmodule

// File: tb/tb_gpr_operand_fetch.sv
// Scoreboard bench for gpr_operand_fetch with a two-cycle-latency register file model.
module tb_gpr_operand_fetch;
    import rfPhoenixPkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_v = 1'b0;
    logic            req_rdy;
    logic [TidMSB:0] req_tid = '0;
    logic [5:0]      req_ra = '0, req_rb = '0, req_rc = '0;
    logic [2:0]      req_mask = '0;
    gpr_addr_t       rf_ra;
    Value            rf_o;
    logic            wb_wr = 1'b0;
    gpr_addr_t       wb_wa = '0;
    Value            wb_i = '0;
    logic            out_v;
    logic            out_rdy = 1'b0;
    logic [TidMSB:0] out_tid;
    Value            out_a, out_b, out_c;

    Value            mem [256];
    gpr_addr_t       ra_q;
    logic            pl_we = 1'b0;
    gpr_addr_t       pl_addr = '0;
    Value            pl_data = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [TidMSB:0] tid;
        Value            a;
        Value            b;
        Value            c;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    gpr_operand_fetch dut (
        .clk      (clk),
        .rst      (rst),
        .req_v    (req_v),
        .req_rdy  (req_rdy),
        .req_tid  (req_tid),
        .req_ra   (req_ra),
        .req_rb   (req_rb),
        .req_rc   (req_rc),
        .req_mask (req_mask),
        .rf_ra    (rf_ra),
        .rf_o     (rf_o),
        .wb_wr    (wb_wr),
        .wb_wa    (wb_wa),
        .wb_i     (wb_i),
        .out_v    (out_v),
        .out_rdy  (out_rdy),
        .out_tid  (out_tid),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_c    (out_c)
    );

    // Address registered at the end of the issue cycle, array read one edge later.
    always @(posedge clk) begin
        ra_q <= rf_ra;
        rf_o <= mem[ra_q];
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (wb_wr) mem[wb_wa] <= wb_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Caller is at a negedge; returns at the next negedge.
    task automatic preload(input gpr_addr_t a, input Value d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Cycle 0 is the accept cycle. hold<0: out_rdy and req_v held high throughout.
    // wcyc<0: no write-back; otherwise one write in cycle wcyc.
    task automatic fetch(input logic [TidMSB:0] tid, input logic [5:0] ra, input logic [5:0] rb,
                         input logic [5:0] rc, input logic [2:0] mask, input int hold,
                         input int wcyc, input gpr_addr_t waddr, input Value wdata);
        gpr_addr_t addr [3];
        Value      pre [3];
        Value      expv [3];
        gpr_addr_t seq [$];
        gpr_addr_t exp_ra;
        int        n, lat;
        bit        done;
        exp_t      e, got;
        addr[0] = {tid, ra};
        addr[1] = {tid, rb};
        addr[2] = {tid, rc};
        for (int k = 0; k < 3; k++) begin
            pre[k]  = mask[k] ? mem[addr[k]] : '0;
            expv[k] = (mask[k] && wcyc >= 0 && waddr == addr[k]) ? wdata : pre[k];
            if (mask[k]) seq.push_back(addr[k]);
        end
        n    = seq.size();
        lat  = (n == 0) ? 1 : n + 3;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            req_v    = (c == 0) || (hold < 0);
            req_tid  = (c == 0) ? tid : ~tid;
            req_ra   = ra; req_rb = rb; req_rc = rc;
            req_mask = mask;
            wb_wr    = (c == wcyc);
            wb_wa    = waddr;
            wb_i     = wdata;
            out_rdy  = (hold < 0) || (c >= lat + hold);
            if (c == 0) begin
                e.tid = tid; e.a = expv[0]; e.b = expv[1]; e.c = expv[2];
                sb_q.push_back(e);
                chk("req_rdy", req_rdy, 1'b1);
            end
            exp_ra = (c >= 1 && c <= n) ? seq[c-1] : '0;
            chk("rf_ra", rf_ra, exp_ra);
            chk("out_v", out_v, c >= lat);
            if (c == lat && wcyc >= lat) begin
                chk("pre_a", out_a, pre[0]);
                chk("pre_b", out_b, pre[1]);
                chk("pre_c", out_c, pre[2]);
            end
            if (out_v && out_rdy) begin
                done = 1'b1;
                chk("sb_depth", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    got = sb_q.pop_front();
                    chk("out_tid", out_tid, got.tid);
                    chk("out_a", out_a, got.a);
                    chk("out_b", out_b, got.b);
                    chk("out_c", out_c, got.c);
                end
            end
        end
        chk("handshake", done, 1'b1);
        @(negedge clk);
        req_v = 1'b0; wb_wr = 1'b0; out_rdy = 1'b0;
        chk("idle_rdy", req_rdy, 1'b1);
        chk("idle_out_v", out_v, 1'b0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_out_v", out_v, 1'b0);
        chk("rst_rf_ra", rf_ra, '0);
        chk("rst_out_tid", out_tid, '0);
        chk("rst_out_a", out_a, '0);
        chk("rst_out_b", out_b, '0);
        chk("rst_out_c", out_c, '0);
    endtask

    initial begin
        @(negedge clk);
        for (int i = 0; i < 256; i++) preload(gpr_addr_t'(i), 32'hD000_0000 ^ (32'(i) * 32'h0001_3579));
        preload({2'd1, 6'd5}, 32'h11);
        preload({2'd0, 6'd1}, 32'hA);
        preload({2'd0, 6'd2}, 32'hB);
        preload({2'd0, 6'd3}, 32'hC);
        preload({2'd0, 6'd4}, 32'h44);
        chk_reset_vals();
        rst = 1'b0;

        fetch(2'd1, 6'd5, 6'd7, 6'd9, 3'b001, 0, -1, '0, '0);
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 0, -1, '0, '0);
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 0, 3, {2'd0, 6'd2}, 32'h55);
        preload({2'd0, 6'd2}, 32'hB);
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 0, 2, {2'd0, 6'd2}, 32'h55);
        preload({2'd0, 6'd2}, 32'hB);
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 0, 4, {2'd0, 6'd2}, 32'h5A);
        preload({2'd0, 6'd2}, 32'hB);
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 5, 7, {2'd0, 6'd3}, 32'h77);
        fetch(2'd2, 6'd8, 6'd9, 6'd10, 3'b000, 0, -1, '0, '0);
        fetch(2'd0, 6'd4, 6'd4, 6'd4, 3'b111, 2, 6, {2'd0, 6'd4}, 32'h99);

        // reset in cycle 2 of a full-mask fetch
        req_v = 1'b1; req_tid = 2'd1; req_ra = 6'd10; req_rb = 6'd11; req_rc = 6'd12; req_mask = 3'b111;
        @(negedge clk);
        req_v = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_reset_vals();
            @(negedge clk);
        end
        fetch(2'd0, 6'd1, 6'd2, 6'd3, 3'b111, 0, -1, '0, '0);

        for (int r = 0; r < 8; r++) begin
            fetch(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)), -1, -1, '0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1);
    end
endmodule
